window3x3_gen: RTL and testbench

WINDOW3X3_GEN -- requirements
Module: window3x3_gen

---
 rtl/window3x3_gen.sv | 123 ++++++++++++
 tb/tb_window3x3_gen.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/window3x3_gen.sv
// Raster-scan 3x3 window generator: two line buffers feed a 3x3 register window
// that emits only fully in-frame (valid-padding) windows, one per accepted pixel.
module window3x3_gen #(
  parameter int IMG_W  = 5,
  parameter int IMG_H  = 5,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pix_in_valid,
  input  logic              pix_in_sof,
  input  logic [DATA_W-1:0] pix_in,
  output logic              win_valid,
  output logic [DATA_W-1:0] win_0,
  output logic [DATA_W-1:0] win_1,
  output logic [DATA_W-1:0] win_2,
  output logic [DATA_W-1:0] win_3,
  output logic [DATA_W-1:0] win_4,
  output logic [DATA_W-1:0] win_5,
  output logic [DATA_W-1:0] win_6,
  output logic [DATA_W-1:0] win_7,
  output logic [DATA_W-1:0] win_8,
  output logic              frame_done,
  output logic              busy
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q;
  logic [CW-1:0]       col_q, col_d, col_cur;
  logic [RW-1:0]       row_q, row_d, row_cur;
  logic                win_valid_q, frame_done_q;
  logic                accept, last_px, win_pos, last_col;
  logic [DATA_W-1:0]   line0_q [IMG_W];
  logic [DATA_W-1:0]   line1_q [IMG_W];
  logic [DATA_W-1:0]   win_q [9];

  // A sof pixel is always position (0,0), even when it aborts a running frame.
  always_comb begin
    accept   = pix_in_valid && (pix_in_sof || (state_q == ACTIVE));
    col_cur  = pix_in_sof ? '0 : col_q;
    row_cur  = pix_in_sof ? '0 : row_q;
    last_col = (col_cur == CW'(IMG_W - 1));
    last_px  = last_col && (row_cur == RW'(IMG_H - 1));
    win_pos  = (row_cur >= RW'(2)) && (col_cur >= CW'(2));
    col_d    = col_q;
    row_d    = row_q;
    if (accept) begin
      if (last_px) begin
        col_d = '0;
        row_d = '0;
      end else if (last_col) begin
        col_d = '0;
        row_d = row_cur + RW'(1);
      end else begin
        col_d = col_cur + CW'(1);
        row_d = row_cur;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_valid_q  <= accept && win_pos;
      frame_done_q <= accept && last_px;
      if (accept) begin
        state_q <= last_px ? IDLE : ACTIVE;
      end
    end
  end

  // Line buffers are never cleared: rows 0-1 never produce a window, so stale
  // contents from an earlier frame are always overwritten before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      line1_q[col_cur] <= line0_q[col_cur];
      line0_q[col_cur] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) begin
        win_q[k] <= '0;
      end
    end else if (accept) begin
      win_q[0] <= win_q[1];
      win_q[1] <= win_q[2];
      win_q[2] <= line1_q[col_cur];
      win_q[3] <= win_q[4];
      win_q[4] <= win_q[5];
      win_q[5] <= line0_q[col_cur];
      win_q[6] <= win_q[7];
      win_q[7] <= win_q[8];
      win_q[8] <= pix_in;
    end
  end

  assign win_valid  = win_valid_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == ACTIVE);
  assign win_0      = win_q[0];
  assign win_1      = win_q[1];
  assign win_2      = win_q[2];
  assign win_3      = win_q[3];
  assign win_4      = win_q[4];
  assign win_5      = win_q[5];
  assign win_6      = win_q[6];
  assign win_7      = win_q[7];
  assign win_8      = win_q[8];

endmodule

// File: tb/tb_window3x3_gen.sv
// Directed bench for window3x3_gen on a 5x5 image: ramp and checkerboard frames,
// gaps, dropped pre-sof pixels, mid-frame abort, mid-frame reset, back-to-back frames.
module tb_window3x3_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       pix_in_valid, pix_in_sof;
  logic [7:0] pix_in;
  logic       win_valid, frame_done, busy;
  logic [7:0] win_0, win_1, win_2, win_3, win_4, win_5, win_6, win_7, win_8;
  logic [7:0] wv [9];

  int checks = 0;
  int errors = 0;
  int wins   = 0;
  int fd_cnt = 0;

  always #5 clk = ~clk;

  window3x3_gen #(.IMG_W(5), .IMG_H(5), .DATA_W(8)) dut (
    .clk(clk), .rst(rst),
    .pix_in_valid(pix_in_valid), .pix_in_sof(pix_in_sof), .pix_in(pix_in),
    .win_valid(win_valid),
    .win_0(win_0), .win_1(win_1), .win_2(win_2), .win_3(win_3), .win_4(win_4),
    .win_5(win_5), .win_6(win_6), .win_7(win_7), .win_8(win_8),
    .frame_done(frame_done), .busy(busy)
  );

  assign wv[0] = win_0;
  assign wv[1] = win_1;
  assign wv[2] = win_2;
  assign wv[3] = win_3;
  assign wv[4] = win_4;
  assign wv[5] = win_5;
  assign wv[6] = win_6;
  assign wv[7] = win_7;
  assign wv[8] = win_8;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // mode 0: ramp r*5+c+1; mode 1: checkerboard (2 on even r+c, 1 on odd)
  function automatic int pv(input int mode, input int r, input int c);
    if (mode == 0) return r * 5 + c + 1;
    return (((r + c) % 2) == 0) ? 2 : 1;
  endfunction

  task automatic step(input logic v, input logic s, input logic [7:0] d);
    pix_in_valid = v;
    pix_in_sof   = s;
    pix_in       = d;
    @(posedge clk);
    #1;
  endtask

  // Sends the first npix pixels of a 5x5 frame (sof on the first) and checks
  // each output cycle; with gaps an idle cycle follows every pixel.
  task automatic frame(input int mode, input bit gaps, input int npix);
    int r, c;
    bit ev;
    logic [7:0] last [9];
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / 5;
      c = idx % 5;
      step(1'b1, idx == 0, 8'(pv(mode, r, c)));
      ev = (r >= 2) && (c >= 2);
      chk("win_valid", win_valid, 32'(ev));
      chk("busy", busy, 32'(idx != 24));
      chk("frame_done", frame_done, 32'(idx == 24));
      if (frame_done === 1'b1) fd_cnt++;
      if (ev) begin
        wins++;
        for (int k = 0; k < 9; k++) begin
          chk($sformatf("win%0d r%0d c%0d", k, r, c), wv[k],
              pv(mode, r - 2 + k / 3, c - 2 + k % 3));
          last[k] = wv[k];
        end
      end
      if (gaps) begin
        step(1'b0, 1'b0, 8'hEE);
        chk("gap win_valid", win_valid, 0);
        chk("gap frame_done", frame_done, 0);
        if (ev) begin
          for (int k = 0; k < 9; k++) begin
            chk($sformatf("gap hold win%0d", k), wv[k], last[k]);
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    pix_in_valid = 1'b0;
    pix_in_sof = 1'b0;
    pix_in = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst win_valid", win_valid, 0);
    chk("rst frame_done", frame_done, 0);
    chk("rst busy", busy, 0);
    chk("rst win4", win_4, 0);
    rst = 1'b0;

    // Pixels without sof are dropped while idle.
    for (int i = 1; i <= 5; i++) begin
      step(1'b1, 1'b0, 8'(i));
      chk("drop win_valid", win_valid, 0);
      chk("drop busy", busy, 0);
      chk("drop win8", win_8, 0);
    end
    wins = 0;
    frame(0, 1'b0, 25);
    chk("contig windows", wins, 9);
    step(1'b0, 1'b0, 8'h00);
    chk("done pulse width", frame_done, 0);
    chk("idle busy", busy, 0);

    // Alternating gaps.
    wins = 0;
    frame(0, 1'b1, 25);
    chk("gap windows", wins, 9);

    // Abort by sof at pixel 15, then checkerboard frame.
    wins = 0;
    fd_cnt = 0;
    frame(0, 1'b0, 14);
    frame(1, 1'b0, 25);
    chk("abort windows", wins, 11);
    chk("abort done count", fd_cnt, 1);

    // Reset at pixel 18 of a ramp frame.
    frame(0, 1'b0, 17);
    rst = 1'b1;
    step(1'b1, 1'b0, 8'd18);
    rst = 1'b0;
    chk("mid rst win_valid", win_valid, 0);
    chk("mid rst frame_done", frame_done, 0);
    chk("mid rst busy", busy, 0);
    for (int k = 0; k < 9; k++) chk($sformatf("mid rst win%0d", k), wv[k], 0);
    step(1'b1, 1'b0, 8'd19);
    chk("post rst drop busy", busy, 0);
    chk("post rst drop win_valid", win_valid, 0);
    wins = 0;
    frame(0, 1'b0, 25);
    chk("post rst windows", wins, 9);

    // Back-to-back frames, second one checkerboard.
    wins = 0;
    fd_cnt = 0;
    frame(0, 1'b0, 25);
    frame(1, 1'b0, 25);
    chk("b2b windows", wins, 18);
    chk("b2b done count", fd_cnt, 2);
    step(1'b0, 1'b0, 8'h00);
    chk("b2b end busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
